// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, keymap and snapshot classifier for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_PEND,
        HELD,
        RELEASE_PEND
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_KEY,
        CLS_MULTI
    } snap_cls_t;

    typedef struct packed {
        snap_cls_t  cls;
        logic [3:0] idx;
    } snap_info_t;

    // Snapshot bit index (col*4 + row) -> hex code; entry 0 is the lowest nibble.
    localparam logic [15:0][3:0] KEYMAP = 64'hDCBA_E963_F852_0741;

    // Counts pressed bits and reports the index of the (last) pressed one.
    function automatic snap_info_t classify(input logic [15:0] snap);
        snap_info_t info;
        int         n;
        info.idx = 4'h0;
        n        = 0;
        for (int i = 0; i < 16; i++) begin
            if (snap[i]) begin
                n        = n + 1;
                info.idx = i[3:0];
            end
        end
        if (n == 0)      info.cls = CLS_NONE;
        else if (n == 1) info.cls = CLS_KEY;
        else             info.cls = CLS_MULTI;
        return info;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad pins, clear input and event/operand outputs
interface keypad_scanner_if;
    logic [3:0]  row;
    logic        clear;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [15:0] operand;
    logic [2:0]  digit_count;

    modport master (
        input  row, clear,
        output col, key_valid, key_code, key_held, operand, digit_count
    );

    modport slave (
        output row, clear,
        input  col, key_valid, key_code, key_held, operand, digit_count
    );
endinterface

// File: rtl/keypad_col_scan.sv
// rtl/keypad_col_scan.sv - column drive, row synchronizer and whole-keypad snapshot
module keypad_col_scan #(
    parameter int CLKS_PER_COL = 100000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_row,
    output logic [3:0]  o_col,
    output logic [15:0] o_snapshot,
    output logic        o_scan_done
);
    localparam int DW_W = $clog2(CLKS_PER_COL);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(CLKS_PER_COL - 1);

    logic [DW_W-1:0] r_dwell;
    logic [1:0]      r_col_idx;
    logic [3:0]      r_col_n;
    logic [3:0]      r_sync1;
    logic [3:0]      r_sync2;
    logic [15:0]     r_snap;
    logic            r_scan_done;

    // Dwell/column sequencing, 2-flop row sync, and capture of pressed rows (active-high) at end of dwell
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dwell     <= '0;
            r_col_idx   <= 2'd0;
            r_col_n     <= 4'b1110;
            r_sync1     <= 4'hF;
            r_sync2     <= 4'hF;
            r_snap      <= 16'h0000;
            r_scan_done <= 1'b0;
        end else begin
            r_sync1     <= i_row;
            r_sync2     <= r_sync1;
            r_scan_done <= 1'b0;
            if (r_dwell == DWELL_LAST) begin
                r_dwell                       <= '0;
                r_col_idx                     <= r_col_idx + 2'd1;
                r_col_n                       <= {r_col_n[2:0], r_col_n[3]};
                r_snap[{r_col_idx, 2'b00} +: 4] <= ~r_sync2;
                if (r_col_idx == 2'd3) begin
                    r_scan_done <= 1'b1;
                end
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end
        end
    end

    assign o_col       = r_col_n;
    assign o_snapshot  = r_snap;
    assign o_scan_done = r_scan_done;
endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scanner with press/release debounce and operand shift register
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLKS_PER_COL   = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    keypad_scanner_if.master kp
);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] DB_CNT = CNT_W'(DEBOUNCE_SCANS);
    localparam bit DB_ONE = (DEBOUNCE_SCANS == 1);

    logic [3:0]       w_col;
    logic [15:0]      w_snapshot;
    logic             w_scan_done;
    snap_info_t       w_info;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_pend_idx;
    logic             r_key_valid;
    logic [3:0]       r_key_code;
    logic             r_key_held;
    logic [15:0]      r_operand;
    logic [2:0]       r_digit_count;

    state_t           w_next_state;
    logic [CNT_W-1:0] w_next_cnt;
    logic [3:0]       w_next_idx;
    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [3:0]       w_new_code;

    keypad_col_scan #(.CLKS_PER_COL(CLKS_PER_COL)) u_col_scan (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_row       (kp.row),
        .o_col       (w_col),
        .o_snapshot  (w_snapshot),
        .o_scan_done (w_scan_done)
    );

    assign w_info     = classify(w_snapshot);
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_new_code = KEYMAP[w_next_idx];

    // Debounce next-state: only a completed scan can move the FSM; no rollover while held
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_idx   = r_pend_idx;
        w_accept     = 1'b0;
        if (w_scan_done) begin
            case (r_state)
                IDLE: begin
                    if (w_info.cls == CLS_KEY) begin
                        w_next_idx = w_info.idx;
                        if (DB_ONE) begin
                            w_next_state = HELD;
                            w_accept     = 1'b1;
                        end else begin
                            w_next_state = PRESS_PEND;
                            w_next_cnt   = CNT_W'(1);
                        end
                    end
                end
                PRESS_PEND: begin
                    if (w_info.cls == CLS_KEY && w_info.idx == r_pend_idx) begin
                        if (w_cnt_inc == DB_CNT) begin
                            w_next_state = HELD;
                            w_accept     = 1'b1;
                        end else begin
                            w_next_cnt = w_cnt_inc;
                        end
                    end else begin
                        w_next_state = IDLE;
                    end
                end
                HELD: begin
                    if (w_info.cls == CLS_NONE) begin
                        if (DB_ONE) begin
                            w_next_state = IDLE;
                        end else begin
                            w_next_state = RELEASE_PEND;
                            w_next_cnt   = CNT_W'(1);
                        end
                    end
                end
                RELEASE_PEND: begin
                    if (w_info.cls == CLS_NONE) begin
                        if (w_cnt_inc == DB_CNT) begin
                            w_next_state = IDLE;
                        end else begin
                            w_next_cnt = w_cnt_inc;
                        end
                    end else begin
                        w_next_state = HELD;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    // FSM state, pending key and registered event outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_pend_idx  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'h0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_pend_idx  <= w_next_idx;
            r_key_valid <= w_accept;
            r_key_held  <= (w_next_state == HELD) || (w_next_state == RELEASE_PEND);
            if (w_accept) begin
                r_key_code <= w_new_code;
            end
        end
    end

    // Operand shift register; a Clear coinciding with an accepted key keeps only that key
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_operand     <= 16'h0000;
            r_digit_count <= 3'd0;
        end else if (kp.clear && w_accept) begin
            r_operand     <= {12'h000, w_new_code};
            r_digit_count <= 3'd1;
        end else if (kp.clear) begin
            r_operand     <= 16'h0000;
            r_digit_count <= 3'd0;
        end else if (w_accept) begin
            r_operand     <= {r_operand[11:0], w_new_code};
            r_digit_count <= (r_digit_count == 3'd4) ? 3'd4 : r_digit_count + 3'd1;
        end
    end

    assign kp.col         = w_col;
    assign kp.key_valid   = r_key_valid;
    assign kp.key_code    = r_key_code;
    assign kp.key_held    = r_key_held;
    assign kp.operand     = r_operand;
    assign kp.digit_count = r_digit_count;
endmodule
